seg_scan_driver: RTL and testbench

Time-multiplexed seven-segment scan driver downstream of the mode/timer blocks (countdown timer, clock, clean-mode timer). Timers present per-digit hex codes plus masks; this block owns the refresh counter, digit rotation, frame-synchronous input capture, blanking, blinking and segment decoding, and drives the board `seg`/`an` pins. Timer blocks no longer run their own scan logic.

---
 rtl/disp_pkg.sv | 47 ++++
 rtl/hex_to_seg7.sv | 38 +++
 rtl/seg_scan_driver.sv | 220 ++++++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the seven-segment display path.
//   - seg7_t            : a..g segment vector, bit 6 = a ... bit 0 = g
//   - SEG_0 .. SEG_F    : active-high segment patterns for hex codes
//   - SEG_DARK          : full 8-bit pattern with every segment and dp off
//   - CODE_DASH         : hex code rendered as a single middle bar
//   - DEF_REFRESH_DIV   : clk cycles per digit slot at 100 MHz (1 ms)
//   - DEF_BLINK_DIV     : clk cycles per blink half-period at 100 MHz (0.5 s)
//   - seg_with_dp()     : packs a..g and the decimal point into the pin order
// -----------------------------------------------------------------------------
package disp_pkg;

  typedef logic [6:0] seg7_t;

  localparam int DEF_REFRESH_DIV = 100_000;
  localparam int DEF_BLINK_DIV   = 50_000_000;

  // Timers use this code for "--" placeholders.
  localparam logic [3:0] CODE_DASH = 4'hF;

  localparam seg7_t SEG_0 = 7'b1111110;
  localparam seg7_t SEG_1 = 7'b0110000;
  localparam seg7_t SEG_2 = 7'b1101101;
  localparam seg7_t SEG_3 = 7'b1111001;
  localparam seg7_t SEG_4 = 7'b0110011;
  localparam seg7_t SEG_5 = 7'b1011011;
  localparam seg7_t SEG_6 = 7'b1011111;
  localparam seg7_t SEG_7 = 7'b1110000;
  localparam seg7_t SEG_8 = 7'b1111111;
  localparam seg7_t SEG_9 = 7'b1111011;
  localparam seg7_t SEG_A = 7'b1110111;
  localparam seg7_t SEG_B = 7'b0011111;
  localparam seg7_t SEG_C = 7'b1001110;
  localparam seg7_t SEG_D = 7'b0111101;
  localparam seg7_t SEG_E = 7'b1001111;
  // Code F is not a hex glyph on this board: it is the dash.
  localparam seg7_t SEG_F = 7'b0000001;

  localparam logic [7:0] SEG_DARK = 8'h00;

  // Board pin order is {a,b,c,d,e,f,g,dp}.
  function automatic logic [7:0] seg_with_dp(input seg7_t s, input logic dp);
    return {s, dp};
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational decoder from a 4-bit digit code to the a..g segment pattern.
// The decimal point is not handled here; the scan driver appends it.
// Ports:
//   code  in  4 : digit code 0..F (F renders as a dash)
//   seg7  out 7 : segments a..g, active-high, bit 6 = a
// -----------------------------------------------------------------------------
import disp_pkg::*;

module hex_to_seg7 (
  input  logic [3:0] code,
  output seg7_t      seg7
);

  always_comb begin
    seg7 = SEG_F;
    case (code)
      4'h0:      seg7 = SEG_0;
      4'h1:      seg7 = SEG_1;
      4'h2:      seg7 = SEG_2;
      4'h3:      seg7 = SEG_3;
      4'h4:      seg7 = SEG_4;
      4'h5:      seg7 = SEG_5;
      4'h6:      seg7 = SEG_6;
      4'h7:      seg7 = SEG_7;
      4'h8:      seg7 = SEG_8;
      4'h9:      seg7 = SEG_9;
      4'hA:      seg7 = SEG_A;
      4'hB:      seg7 = SEG_B;
      4'hC:      seg7 = SEG_C;
      4'hD:      seg7 = SEG_D;
      4'hE:      seg7 = SEG_E;
      CODE_DASH: seg7 = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed seven-segment scan driver. Upstream timers present a hex
// code per digit plus decimal-point, blank and blink masks; this block
// captures them once per frame into shadow registers, rotates through the
// digits, applies blanking/blinking and decodes the segments.
//
// Parameters:
//   NUM_DIGITS   digits scanned (2..8)
//   REFRESH_DIV  clk cycles per digit slot (>= 2)
//   BLINK_DIV    clk cycles per blink half-period (>= 2)
// Ports:
//   clk         in  1             system clock
//   rst_n       in  1             synchronous reset, ACTIVE-HIGH (1 = reset)
//   enable      in  1             scan enable; low keeps the display dark
//   digits      in  4*NUM_DIGITS  hex code per digit, digit 0 rightmost
//   dp_mask     in  NUM_DIGITS    decimal point per digit
//   blank_mask  in  NUM_DIGITS    digit fully dark (segments and dp)
//   blink_mask  in  NUM_DIGITS    digit dark during blink-off phase
//   seg         out 8             {a,b,c,d,e,f,g,dp}, active-high
//   an          out NUM_DIGITS    digit select, active-high, one-hot or zero
//   frame_tick  out 1             pulse in the cycle a frame's inputs land
//                                 in the shadow registers
// -----------------------------------------------------------------------------
import disp_pkg::*;

module seg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int BLINK_DIV   = DEF_BLINK_DIV
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [REF_W-1:0]        ref_cnt_reg,   ref_cnt_next;
  logic [IDX_W-1:0]        idx_reg,       idx_next;
  // High once the scan has had one enabled cycle; that first cycle is spent
  // capturing the frame, so slot 0 starts counting only afterwards.
  logic                    started_reg,   started_next;
  logic [4*NUM_DIGITS-1:0] code_sh_reg,   code_sh_next;
  logic [NUM_DIGITS-1:0]   dp_sh_reg,     dp_sh_next;
  logic [NUM_DIGITS-1:0]   blank_sh_reg,  blank_sh_next;
  logic [NUM_DIGITS-1:0]   blink_sh_reg,  blink_sh_next;
  logic [BLK_W-1:0]        blink_cnt_reg, blink_cnt_next;
  logic                    blink_on_reg,  blink_on_next;
  logic [7:0]              seg_reg,       seg_next;
  logic [NUM_DIGITS-1:0]   an_reg,        an_next;
  logic                    frame_tick_reg, frame_tick_next;

  // ---------------------------------------------------------------------------
  // Control decodes
  // ---------------------------------------------------------------------------
  logic active;
  logic ref_last;
  logic idx_last;
  logic capture;
  logic blink_last;

  assign active     = enable & started_reg;
  assign ref_last   = (ref_cnt_reg == REF_W'(REFRESH_DIV - 1));
  assign idx_last   = (idx_reg == IDX_W'(NUM_DIGITS - 1));
  assign blink_last = (blink_cnt_reg == BLK_W'(BLINK_DIV - 1));

  // A frame is captured either on the first enabled cycle or on the cycle
  // whose clock edge wraps idx back to 0. In both cases the new shadow
  // contents first reach the pins one cycle after frame_tick.
  assign capture = enable & (~started_reg | (ref_last & idx_last));

  // ---------------------------------------------------------------------------
  // Per-digit views of the shadow registers
  // ---------------------------------------------------------------------------
  logic [3:0]            code_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] an_slot;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign code_arr[gi] = code_sh_reg[4*gi +: 4];
    assign an_slot[gi]  = (idx_reg == IDX_W'(gi));
  end

  // Select the current slot's shadow values. Written as a compare loop so an
  // idx value beyond NUM_DIGITS-1 (impossible in operation) selects nothing.
  logic [3:0] cur_code;
  logic       cur_dp;
  logic       cur_blank;
  logic       cur_blink;

  always_comb begin
    cur_code  = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_blink = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        cur_code  = code_arr[i];
        cur_dp    = dp_sh_reg[i];
        cur_blank = blank_sh_reg[i];
        cur_blink = blink_sh_reg[i];
      end
    end
  end

  seg7_t cur_seg7;

  hex_to_seg7 u_dec (
    .code (cur_code),
    .seg7 (cur_seg7)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    ref_cnt_next    = ref_cnt_reg;
    idx_next        = idx_reg;
    started_next    = enable;
    code_sh_next    = code_sh_reg;
    dp_sh_next      = dp_sh_reg;
    blank_sh_next   = blank_sh_reg;
    blink_sh_next   = blink_sh_reg;
    blink_cnt_next  = blink_cnt_reg;
    blink_on_next   = blink_on_reg;
    seg_next        = SEG_DARK;
    an_next         = '0;
    frame_tick_next = capture;

    // Slot rotation: parked at slot 0 while disabled or on the capture-only
    // first cycle.
    if (!enable) begin
      ref_cnt_next = '0;
      idx_next     = '0;
    end else if (started_reg) begin
      if (ref_last) begin
        ref_cnt_next = '0;
        idx_next     = idx_last ? '0 : idx_reg + IDX_W'(1);
      end else begin
        ref_cnt_next = ref_cnt_reg + REF_W'(1);
      end
    end

    if (capture) begin
      code_sh_next  = digits;
      dp_sh_next    = dp_mask;
      blank_sh_next = blank_mask;
      blink_sh_next = blink_mask;
    end

    // Blink phase runs regardless of enable so blinking stays steady across
    // brief display-off periods.
    if (blink_last) begin
      blink_cnt_next = '0;
      blink_on_next  = ~blink_on_reg;
    end else begin
      blink_cnt_next = blink_cnt_reg + BLK_W'(1);
    end

    // Outputs for the slot idx currently points at; they appear next cycle.
    if (active) begin
      an_next = an_slot;
      if (cur_blank || (cur_blink && !blink_on_reg)) begin
        seg_next = SEG_DARK;
      end else begin
        seg_next = seg_with_dp(cur_seg7, cur_dp);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ref_cnt_reg    <= '0;
      idx_reg        <= '0;
      started_reg    <= 1'b0;
      code_sh_reg    <= '0;
      dp_sh_reg      <= '0;
      blank_sh_reg   <= '0;
      blink_sh_reg   <= '0;
      blink_cnt_reg  <= '0;
      blink_on_reg   <= 1'b1;
      seg_reg        <= SEG_DARK;
      an_reg         <= '0;
      frame_tick_reg <= 1'b0;
    end else begin
      ref_cnt_reg    <= ref_cnt_next;
      idx_reg        <= idx_next;
      started_reg    <= started_next;
      code_sh_reg    <= code_sh_next;
      dp_sh_reg      <= dp_sh_next;
      blank_sh_reg   <= blank_sh_next;
      blink_sh_reg   <= blink_sh_next;
      blink_cnt_reg  <= blink_cnt_next;
      blink_on_reg   <= blink_on_next;
      seg_reg        <= seg_next;
      an_reg         <= an_next;
      frame_tick_reg <= frame_tick_next;
    end
  end

  assign seg        = seg_reg;
  assign an         = an_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Directed bench for seg_scan_driver with NUM_DIGITS=3, REFRESH_DIV=4,
// BLINK_DIV=16. Frame position k counts cycles after the frame_tick cycle
// (k=0): slot s is shown for k in 4s+1..4s+4, the next tick lands at k=12.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int ND = 3;
  localparam int RD = 4;
  localparam int BD = 16;
  localparam int FRAME = ND * RD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [11:0]   digits;
  logic [2:0]    dp_mask;
  logic [2:0]    blank_mask;
  logic [2:0]    blink_mask;
  logic [7:0]    seg;
  logic [2:0]    an;
  logic          frame_tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // cycles since reset release; equals the blink counter

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLINK_DIV   (BD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  typedef struct {
    logic [11:0] d;
    logic [2:0]  dp;
    logic [2:0]  bl;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [7:0]  e2;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns at the negedge where frame_tick is seen high (k = 0).
  task automatic wait_tick();
    bit found = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("tick_timeout", {31'b0, found}, 32'd1);
  endtask

  // Checks an/seg/frame_tick for frame positions k_from..k_to.
  // With blink0 set, slot 0 is dark when blink_on was low in the previous
  // cycle; blink_on is high for blink counts 0..15, low for 16..31, etc.
  task automatic check_span(input int k_from, input int k_to,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input bit blink0);
    int          slot;
    logic [2:0]  exp_an;
    logic [7:0]  exp_seg;
    for (int k = k_from; k <= k_to; k++) begin
      @(negedge clk);
      slot    = ((k - 1) / RD) % ND;
      exp_an  = 3'b001 << slot;
      exp_seg = (slot == 0) ? e0 : (slot == 1) ? e1 : e2;
      if (slot == 0 && blink0 && (((cyc - 1) / BD) % 2) != 0) exp_seg = 8'h00;
      check($sformatf("an k=%0d", k), {29'b0, an}, {29'b0, exp_an});
      check($sformatf("seg k=%0d", k), {24'b0, seg}, {24'b0, exp_seg});
      check($sformatf("tick k=%0d", k), {31'b0, frame_tick}, {31'b0, (k % FRAME) == 0});
    end
  endtask

  task automatic check_dark(input string name);
    check({name, "_an"},   {29'b0, an},         32'd0);
    check({name, "_seg"},  {24'b0, seg},        32'd0);
    check({name, "_tick"}, {31'b0, frame_tick}, 32'd0);
  endtask

  initial begin
    //        digits   dp      blank   slot0  slot1  slot2
    vecs[0] = '{12'h359, 3'b010, 3'b000, 8'hF6, 8'hB7, 8'hF2};
    vecs[1] = '{12'hFFF, 3'b000, 3'b000, 8'h02, 8'h02, 8'h02};
    vecs[2] = '{12'h0A8, 3'b101, 3'b000, 8'hFF, 8'hEE, 8'hFD};
    vecs[3] = '{12'hBCD, 3'b000, 3'b000, 8'h7A, 8'h9C, 8'h3E};
    vecs[4] = '{12'h467, 3'b000, 3'b010, 8'hE0, 8'h00, 8'h66};
    vecs[5] = '{12'h1E6, 3'b110, 3'b100, 8'hBE, 8'h9F, 8'h00};

    rst_n      = 1'b1;
    enable     = 1'b1;
    digits     = 12'h123;
    dp_mask    = 3'b000;
    blank_mask = 3'b000;
    blink_mask = 3'b000;

    // Reset held with enable high: everything dark.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_dark($sformatf("reset%0d", i));
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("first_tick", {31'b0, frame_tick}, 32'd1);
    check("first_tick_an", {29'b0, an}, 32'd0);
    check_span(1, FRAME, 8'hF2, 8'hDA, 8'h60, 1'b0);
    $display("reset release: frame of 123 scanned, checks=%0d errors=%0d", checks, errors);

    // Table of decode / dp / blank vectors, one frame each.
    for (int v = 0; v < 6; v++) begin
      digits     = vecs[v].d;
      dp_mask    = vecs[v].dp;
      blank_mask = vecs[v].bl;
      wait_tick();
      check_span(1, FRAME, vecs[v].e0, vecs[v].e1, vecs[v].e2, 1'b0);
      $display("vector %0d: digits=%03h dp=%03b blank=%03b checks=%0d errors=%0d",
               v, vecs[v].d, vecs[v].dp, vecs[v].bl, checks, errors);
    end

    // Tear-free capture: change digits mid-slot 1.
    digits     = 12'h123;
    dp_mask    = 3'b000;
    blank_mask = 3'b000;
    wait_tick();
    check_span(1, 6, 8'hF2, 8'hDA, 8'h60, 1'b0);
    digits = 12'h456;
    check_span(7, FRAME, 8'hF2, 8'hDA, 8'h60, 1'b0);
    check_span(FRAME + 1, 2 * FRAME, 8'hBE, 8'hB6, 8'h66, 1'b0);
    $display("tear test: 123 -> 456 mid-frame, checks=%0d errors=%0d", checks, errors);

    // Blank slot 2, blink slot 0 across several blink half-periods.
    digits     = 12'h123;
    blank_mask = 3'b100;
    blink_mask = 3'b001;
    wait_tick();
    check_span(1, 4 * FRAME, 8'hF2, 8'hDA, 8'h00, 1'b1);
    $display("blink test: blank=100 blink=001, checks=%0d errors=%0d", checks, errors);

    // Enable drop during slot 2, then re-enable with new inputs.
    digits     = 12'h789;
    blank_mask = 3'b000;
    blink_mask = 3'b000;
    wait_tick();
    check_span(1, 9, 8'hF6, 8'hFE, 8'hE0, 1'b0);
    enable = 1'b0;
    digits = 12'h21F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_dark($sformatf("disabled%0d", i));
    end
    enable = 1'b1;
    @(negedge clk);
    check("reenable_tick", {31'b0, frame_tick}, 32'd1);
    check("reenable_an", {29'b0, an}, 32'd0);
    check_span(1, FRAME, 8'h02, 8'h60, 8'hDA, 1'b0);
    $display("enable drop/re-enable: new frame 21F, checks=%0d errors=%0d", checks, errors);

    // Reset in the middle of slot 1 abandons the frame.
    check_span(FRAME + 1, FRAME + 6, 8'h02, 8'h60, 8'hDA, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_dark("midreset");
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_tick", {31'b0, frame_tick}, 32'd1);
    check_span(1, FRAME, 8'h02, 8'h60, 8'hDA, 1'b0);
    $display("mid-frame reset: restart at slot 0, checks=%0d errors=%0d", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
